// File: rtl/stream_source_32.sv
// Buffered stream source: a loader fills a DEPTH-word buffer, then a start pulse
// streams the first len words out over a valid/ready master port.
module stream_source_32 #(
  parameter int T     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [T-1:0]        wr_data,
  input  logic                start,
  input  logic [AW-1:0]       len,
  output logic                busy,
  output logic                done,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out
);

  // Handshake: a word moves on a rising edge where m_valid && m_ready; while
  // m_valid is high and m_ready low, m_valid and data_out hold; m_valid is a
  // register and never depends on m_ready combinationally.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [T-1:0] mem [DEPTH];
  logic [T-1:0] rd_q;
  logic [T-1:0] sk_data;
  logic         rd_vld;
  logic         sk_v;
  logic         done_q;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  rem;
  logic [AW:0]  count_c;
  logic [1:0]   occ;
  logic [AW-1:0] rd_addr;
  logic         start_ok;
  logic         run_issue;
  logic         rd_issue;
  logic         pop;
  logic         last_pop;

  assign count_c  = (len == '0) ? (AW+1)'(DEPTH) : {1'b0, len};
  assign start_ok = (state == S_IDLE) && start && !done_q;
  assign pop      = m_valid && m_ready;
  assign last_pop = pop && !sk_v && !rd_vld;

  // Words in flight (output, skid, read register) minus the one leaving now;
  // a new read is safe only if at most one remains, so the skid never overflows.
  assign occ       = 2'(m_valid) + 2'(sk_v) + 2'(rd_vld);
  assign run_issue = (state == S_RUN) && (rem != '0) && (occ <= (2'(pop) + 2'd1));
  assign rd_issue  = start_ok || run_issue;
  assign rd_addr   = start_ok ? '0 : rd_ptr[AW-1:0];

  // Buffer is never cleared, so its contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE)) mem[wr_addr] <= wr_data;
    if (rd_issue) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = (count_c == (AW+1)'(1)) ? S_DRAIN : S_RUN;
      S_RUN:   if (run_issue && (rem == (AW+1)'(1))) state_nx = S_DRAIN;
      S_DRAIN: if (last_pop) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = done_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld   <= 1'b0;
      sk_v     <= 1'b0;
      sk_data  <= '0;
      m_valid  <= 1'b0;
      data_out <= '0;
      done_q   <= 1'b0;
      rd_ptr   <= '0;
      rem      <= '0;
    end else begin
      done_q <= (state == S_DRAIN) && last_pop;
      rd_vld <= rd_issue;
      if (start_ok) begin
        rd_ptr <= (AW+1)'(1);
        rem    <= count_c - (AW+1)'(1);
      end else if (run_issue) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        rem    <= rem - (AW+1)'(1);
      end
      // Output register refills from the skid first to keep address order.
      if (!m_valid || pop) begin
        if (sk_v) begin
          data_out <= sk_data;
          m_valid  <= 1'b1;
          sk_v     <= rd_vld;
          if (rd_vld) sk_data <= rd_q;
        end else if (rd_vld) begin
          data_out <= rd_q;
          m_valid  <= 1'b1;
        end else begin
          m_valid  <= 1'b0;
        end
      end else if (rd_vld) begin
        sk_data <= rd_q;
        sk_v    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/stream_source_32.md
Name: stream_source_32

Overview:
- Transmit-side companion for the layer blocks: a buffered stream source that drives the slave stream port of a layer (s_valid/s_ready/data_in).
- Software or a loader fills an internal word buffer through a simple write port. A start pulse then streams the first len words out over a valid/ready master interface with full backpressure support.
- Sustains one word per cycle while the consumer is ready. Used to feed inputs and weights into layer_* blocks in system-level integration.

Parameters:
- T, 32, data word width in bits
- DEPTH, 16, number of words in the internal buffer (power of two, at least 2)
- AW, $clog2(DEPTH), address/length field width

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  buffer write strobe
- wr_addr  input  AW  buffer write address
- wr_data  input  T  buffer write data
- start  input  1  begin a transfer, sampled on the rising edge
- len  input  AW  word count, sampled with start; 0 means DEPTH
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the last word is accepted
- m_valid  output  1  output word valid
- m_ready  input  1  consumer ready
- data_out  output  T  output word (signed)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - busy=0, done=0, m_valid=0, data_out=0, read pointer=0, FSM=IDLE.
  - Buffer contents are not cleared and are retained across reset.
  - Reset takes effect immediately, even mid-transfer: m_valid drops without completing a handshake and no done pulse is produced.
- Buffer:
  - DEPTH x T, synchronous write, synchronous read with 1-cycle latency.
  - wr_en is honoured only in IDLE; in RUN or DRAIN writes are ignored.
- FSM states:
  - IDLE: busy=0. On the edge where start=1: latch count = (len==0 ? DEPTH : len), issue read of address 0, go to RUN, busy=1 from the next cycle.
  - RUN: issues buffer reads ahead of the output. A 2-entry output skid register holds prefetched words, so sustained throughput is 1 word/cycle with m_ready held high. When the last read has been issued, go to DRAIN.
  - DRAIN: no further reads. Remain until the final word handshakes (m_valid && m_ready), then go to IDLE. done=1 for exactly the following cycle; busy=0 in that same cycle.
- Latency: with m_ready=1, m_valid rises 2 cycles after the start edge carrying word 0. Word k appears in cycle 2+k.
- Handshake rules:
  - A transfer occurs on an edge where m_valid && m_ready.
  - While m_valid=1 and m_ready=0, data_out and m_valid hold stable.
  - m_valid never depends combinationally on m_ready.
  - data_out holds its last value when m_valid=0.
  - No bubbles while m_ready=1, no reads beyond count, and words are emitted strictly in address order 0..count-1.
- start while busy=1: ignored.
- start on the same edge as done: ignored; a new start is accepted only when busy=0 and done=0.
- wr_en and start asserted on the same edge in IDLE: the write commits. The transfer reads the old contents of that address if it is address 0, otherwise the new contents.
- Arithmetic:
  - Read pointer and remaining counters are AW+1 bits so that count=DEPTH is representable.
  - The pointer never wraps within a transfer.
- m_ready toggling randomly must not lose, duplicate or reorder words.

Test Plan:
- Reset, load addr i = i*3-5 for i=0..15, start with len=4, m_ready=1 -> data_out sequence -5,-2,1,4. m_valid first high 2 cycles after start. done pulses once, 1 cycle after the 4th handshake.
- len=0 with m_ready=1 -> 16 words delivered on 16 consecutive cycles, no bubbles; busy high throughout, then done pulse.
- Random m_ready at 50% (same style as the layer benches) over 1000 back-to-back transfers of len=16 -> every word matches the buffer in order, zero errors, exactly one done per transfer; data_out stable whenever m_valid=1 and m_ready=0.
- Writes to addr 2 with 32'hDEADBEEF while busy -> ignored; next transfer still reads the old value. start pulsed mid-transfer -> no effect on count or ordering.
- reset_n asserted low after the 5th handshake of a len=16 transfer -> m_valid=0 and busy=0 immediately. After release, a start with len=2 yields the original words 0 and 1 (buffer retained).
- len=1 with m_ready held low 10 cycles, then high -> m_valid stays high with word 0 for the 10 cycles, one handshake, done pulse, return to IDLE.
